// File: rtl/cc_level_pkg.sv
// Shared definitions for the level sequencer slice.
//   state_t            : game-flow FSM states
//   LEVEL_W, LIVES_W   : widths of the level index and the lives counter
//   DEF_*              : default values for the sequencer parameters
package cc_level_pkg;

  localparam int unsigned LEVEL_W = 4;
  localparam int unsigned LIVES_W = 2;

  localparam int unsigned DEF_NUM_LEVELS = 4;
  localparam int unsigned DEF_LIVES_INIT = 3;
  localparam int unsigned DEF_HOLD_TICKS = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_PLAY     = 3'd2,
    ST_WIN_HOLD = 3'd3,
    ST_DIE_HOLD = 3'd4,
    ST_GAMEOVER = 3'd5,
    ST_VICTORY  = 3'd6
  } state_t;

endpackage

// File: rtl/cc_hold_counter.sv
// Tick-qualified hold counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear; ticks are ignored while asserted
//   tick       : game-tick strobe; each one advances the count
//   done       : high in the cycle whose tick brings the count to HOLD_TICKS,
//                so the caller can act on the same edge that completes the count
// The count saturates at HOLD_TICKS and never wraps.
module cc_hold_counter #(
  parameter int unsigned HOLD_TICKS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic tick,
  output logic done
);

  localparam int unsigned CNT_W = $clog2(HOLD_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HOLD_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_TICKS - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (tick && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign done = !clr && tick && (count == CNT_LAST);

endmodule

// File: rtl/cc_level_sequencer.sv
// Game-flow controller sequencing the level-pattern comparator.
//   CC_LEVELSEQUENCER_CLOCK_50         : clock
//   CC_LEVELSEQUENCER_RESET_InLow      : asynchronous active-low reset
//   CC_LEVELSEQUENCER_START_In         : start request pulse
//   CC_LEVELSEQUENCER_TICK_In          : game-tick strobe
//   CC_LEVELSEQUENCER_GOAL_In          : frog reached the top row
//   CC_LEVELSEQUENCER_COLLISION_In     : frog overlaps an obstacle
//   CC_LEVELSEQUENCER_LEVELCOUNTER_Out : level index to the comparator
//   CC_LEVELSEQUENCER_LOAD_Out         : one-cycle screen reload pulse
//   CC_LEVELSEQUENCER_RUN_Out          : scrolling / frog movement enable
//   CC_LEVELSEQUENCER_LIVES_Out        : remaining lives
//   CC_LEVELSEQUENCER_GAMEOVER_Out     : high in GAMEOVER
//   CC_LEVELSEQUENCER_VICTORY_Out      : high in VICTORY
// All outputs are registered from the next-state decode.
module cc_level_sequencer
  import cc_level_pkg::*;
#(
  parameter int unsigned NUM_LEVELS = DEF_NUM_LEVELS,
  parameter int unsigned LIVES_INIT = DEF_LIVES_INIT,
  parameter int unsigned HOLD_TICKS = DEF_HOLD_TICKS
) (
  input  logic               CC_LEVELSEQUENCER_CLOCK_50,
  input  logic               CC_LEVELSEQUENCER_RESET_InLow,
  input  logic               CC_LEVELSEQUENCER_START_In,
  input  logic               CC_LEVELSEQUENCER_TICK_In,
  input  logic               CC_LEVELSEQUENCER_GOAL_In,
  input  logic               CC_LEVELSEQUENCER_COLLISION_In,
  output logic [LEVEL_W-1:0] CC_LEVELSEQUENCER_LEVELCOUNTER_Out,
  output logic               CC_LEVELSEQUENCER_LOAD_Out,
  output logic               CC_LEVELSEQUENCER_RUN_Out,
  output logic [LIVES_W-1:0] CC_LEVELSEQUENCER_LIVES_Out,
  output logic               CC_LEVELSEQUENCER_GAMEOVER_Out,
  output logic               CC_LEVELSEQUENCER_VICTORY_Out
);

  localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
  localparam logic [LIVES_W-1:0] LIVES_START = LIVES_W'(LIVES_INIT);

  logic clk;
  logic rst_n;
  assign clk   = CC_LEVELSEQUENCER_CLOCK_50;
  assign rst_n = CC_LEVELSEQUENCER_RESET_InLow;

  state_t             state, state_n;
  logic [LEVEL_W-1:0] level, level_n;
  logic [LIVES_W-1:0] lives, lives_n;
  logic               load_q, run_q, gameover_q, victory_q;
  logic               in_hold, in_hold_d, hold_clr, hold_done;

  // The counter is held clear outside the hold states and during the first
  // hold cycle, so a tick coinciding with hold entry is not counted.
  assign in_hold  = (state == ST_WIN_HOLD) || (state == ST_DIE_HOLD);
  assign hold_clr = !(in_hold && in_hold_d);

  cc_hold_counter #(
    .HOLD_TICKS(HOLD_TICKS)
  ) u_hold (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (hold_clr),
    .tick (CC_LEVELSEQUENCER_TICK_In),
    .done (hold_done)
  );

  always_comb begin
    state_n = state;
    level_n = level;
    lives_n = lives;
    case (state)
      ST_IDLE, ST_GAMEOVER, ST_VICTORY: begin
        if (CC_LEVELSEQUENCER_START_In) begin
          state_n = ST_LOAD;
          level_n = '0;
          lives_n = LIVES_START;
        end
      end
      ST_LOAD: begin
        state_n = ST_PLAY;
      end
      ST_PLAY: begin
        if (CC_LEVELSEQUENCER_COLLISION_In) begin
          if (lives <= LIVES_W'(1)) begin
            lives_n = '0;
            state_n = ST_GAMEOVER;
          end else begin
            lives_n = lives - LIVES_W'(1);
            state_n = ST_DIE_HOLD;
          end
        end else if (CC_LEVELSEQUENCER_GOAL_In) begin
          state_n = (level == LAST_LEVEL) ? ST_VICTORY : ST_WIN_HOLD;
        end
      end
      ST_WIN_HOLD: begin
        if (hold_done) begin
          state_n = ST_LOAD;
          level_n = level + LEVEL_W'(1);
        end
      end
      ST_DIE_HOLD: begin
        if (hold_done) begin
          state_n = ST_LOAD;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      level      <= '0;
      lives      <= '0;
      load_q     <= 1'b0;
      run_q      <= 1'b0;
      gameover_q <= 1'b0;
      victory_q  <= 1'b0;
      in_hold_d  <= 1'b0;
    end else begin
      state      <= state_n;
      level      <= level_n;
      lives      <= lives_n;
      load_q     <= (state_n == ST_LOAD);
      run_q      <= (state_n == ST_PLAY);
      gameover_q <= (state_n == ST_GAMEOVER);
      victory_q  <= (state_n == ST_VICTORY);
      in_hold_d  <= in_hold;
    end
  end

  assign CC_LEVELSEQUENCER_LEVELCOUNTER_Out = level;
  assign CC_LEVELSEQUENCER_LOAD_Out         = load_q;
  assign CC_LEVELSEQUENCER_RUN_Out          = run_q;
  assign CC_LEVELSEQUENCER_LIVES_Out        = lives;
  assign CC_LEVELSEQUENCER_GAMEOVER_Out     = gameover_q;
  assign CC_LEVELSEQUENCER_VICTORY_Out      = victory_q;

endmodule

// File: tb/tb_cc_level_sequencer.sv
// Bench for cc_level_sequencer: directed game scenarios followed by random
// stimulus, checked through an expectation queue against a game-rule model.
module tb_cc_level_sequencer;

  localparam int NUM_LEVELS = 4;
  localparam int LIVES_INIT = 3;
  localparam int HOLD_TICKS = 8;

  logic       clk = 1'b0;
  logic       rst_n, start, tick, goal, coll;
  logic [3:0] level;
  logic [1:0] lives;
  logic       load, run, gameover, victory;

  always #5 clk = ~clk;

  cc_level_sequencer #(
    .NUM_LEVELS(NUM_LEVELS),
    .LIVES_INIT(LIVES_INIT),
    .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .CC_LEVELSEQUENCER_CLOCK_50        (clk),
    .CC_LEVELSEQUENCER_RESET_InLow     (rst_n),
    .CC_LEVELSEQUENCER_START_In        (start),
    .CC_LEVELSEQUENCER_TICK_In         (tick),
    .CC_LEVELSEQUENCER_GOAL_In         (goal),
    .CC_LEVELSEQUENCER_COLLISION_In    (coll),
    .CC_LEVELSEQUENCER_LEVELCOUNTER_Out(level),
    .CC_LEVELSEQUENCER_LOAD_Out        (load),
    .CC_LEVELSEQUENCER_RUN_Out         (run),
    .CC_LEVELSEQUENCER_LIVES_Out       (lives),
    .CC_LEVELSEQUENCER_GAMEOVER_Out    (gameover),
    .CC_LEVELSEQUENCER_VICTORY_Out     (victory)
  );

  typedef struct packed {
    logic [3:0] level;
    logic [1:0] lives;
    logic       load;
    logic       run;
    logic       go;
    logic       vic;
  } obs_t;

  obs_t        exp_q[$];
  obs_t        dut_obs;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  assign dut_obs = {level, lives, load, run, gameover, victory};

  // Game-rule model: what the player would see, tracked with plain flags.
  int m_level, m_lives, m_ticks;
  bit m_reloading, m_playing, m_lost, m_won, m_frozen, m_frozen_by_win, m_just_frozen;

  task automatic model_reset();
    m_level = 0; m_lives = 0; m_ticks = 0;
    m_reloading = 0; m_playing = 0; m_lost = 0; m_won = 0;
    m_frozen = 0; m_frozen_by_win = 0; m_just_frozen = 0;
  endtask

  task automatic freeze(input bit by_win);
    m_playing = 0; m_frozen = 1; m_frozen_by_win = by_win;
    m_ticks = 0; m_just_frozen = 1;
  endtask

  task automatic model_step(input bit s, input bit t, input bit g, input bit c);
    if (m_reloading) begin
      m_reloading = 0;
      m_playing   = 1;
    end else if (m_playing) begin
      if (c) begin
        m_lives = m_lives - 1;
        if (m_lives == 0) begin
          m_playing = 0;
          m_lost    = 1;
        end else begin
          freeze(1'b0);
        end
      end else if (g) begin
        if (m_level == NUM_LEVELS - 1) begin
          m_playing = 0;
          m_won     = 1;
        end else begin
          freeze(1'b1);
        end
      end
    end else if (m_frozen) begin
      if (m_just_frozen) begin
        m_just_frozen = 0;
      end else if (t) begin
        m_ticks = m_ticks + 1;
        if (m_ticks == HOLD_TICKS) begin
          m_frozen    = 0;
          m_reloading = 1;
          if (m_frozen_by_win) m_level = m_level + 1;
        end
      end
    end else if (s) begin
      m_level = 0; m_lives = LIVES_INIT;
      m_lost = 0; m_won = 0; m_reloading = 1;
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.level = 4'(m_level);
    o.lives = 2'(m_lives);
    o.load  = m_reloading;
    o.run   = m_playing;
    o.go    = m_lost;
    o.vic   = m_won;
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got lvl=%0d lives=%0d load=%b run=%b go=%b vic=%b, expected lvl=%0d lives=%0d load=%b run=%b go=%b vic=%b",
               name, $time, act.level, act.lives, act.load, act.run, act.go, act.vic,
               exp.level, exp.lives, exp.load, exp.run, exp.go, exp.vic);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare just after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check("cycle", dut_obs, exp_q.pop_front());
    end
  end

  task automatic cyc(input bit s, input bit t, input bit g, input bit c);
    @(negedge clk);
    rst_n = 1'b1; start = s; tick = t; goal = g; coll = c;
    model_step(s, t, g, c);
    exp_q.push_back(model_obs());
  endtask

  task automatic rst_cycle();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b1; tick = 1'b1; goal = 1'b1; coll = 1'b1;
    #1;
    check("async_reset", dut_obs, '0);
    model_reset();
    exp_q.push_back(model_obs());
  endtask

  task automatic win_level();
    cyc(0, 0, 1, 0);
    repeat (HOLD_TICKS + 1) cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
  endtask

  task automatic lose_life();
    cyc(0, 0, 1, 1);
    repeat (HOLD_TICKS + 1) cyc(1, 1, 1, 1);
    cyc(0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; tick = 1'b0; goal = 1'b0; coll = 1'b0;
    model_reset();
    #1;
    check("reset_state", dut_obs, '0);
    repeat (3) rst_cycle();

    // Start, climb to the last level, then win.
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    repeat (NUM_LEVELS - 1) win_level();
    cyc(0, 0, 1, 0);
    repeat (3) cyc(0, 1, 1, 1);

    // Restart, reach level 2, lose all lives there.
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    repeat (2) win_level();
    repeat (LIVES_INIT - 1) lose_life();
    cyc(0, 0, 0, 1);
    repeat (3) cyc(0, 1, 1, 1);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // Reset in the middle of a win hold after five counted ticks.
    cyc(0, 0, 1, 0);
    repeat (6) cyc(0, 1, 0, 0);
    repeat (2) rst_cycle();
    cyc(1, 0, 0, 0);

    // Random play with occasional mid-game resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) rst_cycle();
      else cyc($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
    end

    @(negedge clk);
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
